polygon_vertex_loader: RTL and testbench
========================================

Name: polygon_vertex_loader

Overview:
- Double-buffered vertex store and load sequencer that configures the vertex arrays and point count of a draw_polygon instance.
- The physics/game-logic side streams one polygon's vertices in through a valid/ready handshake into a shadow buffer.
- The committed polygon is swapped into the active buffer only on a frame boundary, so the renderer never sees a half-updated polygon mid-frame.

Parameters:
- MAX_NUM_VERTICES, 32, capacity of shadow and active buffers; must match the driven draw_polygon.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous active-high reset.
- new_frame_in  input  1  single-cycle pulse at start of vertical blank.
- vertex_valid_in  input  1  producer has a vertex.
- vertex_ready_out  output  1  loader accepts a vertex this cycle.
- vertex_x_in  input  32 signed  vertex world x.
- vertex_y_in  input  32 signed  vertex world y.
- vertex_last_in  input  1  marks the final vertex of the polygon.
- xs_out  output  32 signed x MAX_NUM_VERTICES  active x array to draw_polygon.
- ys_out  output  32 signed x MAX_NUM_VERTICES  active y array to draw_polygon.
- num_points_out  output  $clog2(MAX_NUM_VERTICES+1)  active vertex count.
- polygon_valid_out  output  1  active buffer holds a valid polygon; renderer masks its valid_out with this.
- swap_done_out  output  1  one-cycle pulse, active buffer updated.
- error_out  output  1  one-cycle pulse, load rejected.

Behaviour:
- Transfer: a vertex transfers on any rising edge where vertex_valid_in && vertex_ready_out.
- Ready: vertex_ready_out = (state != PENDING) && !rst_in. It is combinational from state.
- FSM states: IDLE, LOAD, PENDING. Internal count register and sticky overflow flag.
- IDLE, on transfer:
  - Write shadow[0] and set count=1.
  - If vertex_last_in: pulse error_out and stay in IDLE.
  - Otherwise go to LOAD.
- LOAD, on transfer with count < MAX_NUM_VERTICES: write shadow[count], count+1.
- LOAD, on transfer with count == MAX_NUM_VERTICES: drop the vertex (still accepted) and set overflow.
- LOAD, on transfer with vertex_last_in:
  - The last vertex itself is stored or dropped per the two rules above.
  - If overflow is set or final count < 3: pulse error_out, clear overflow, go to IDLE.
  - Otherwise go to PENDING.
- PENDING:
  - No transfers accepted.
  - When new_frame_in is sampled high: active[i] = shadow[i] for i < count and active[i] = 0 for i >= count; num_points_out = count; polygon_valid_out = 1; swap_done_out pulses; go to IDLE.
- Latency: outputs change on the edge where new_frame_in is sampled in PENDING, visible from the following cycle. vertex_ready_out goes high the cycle after.
- Frame pulses outside PENDING: new_frame_in in IDLE or LOAD has no effect. The active buffer and the in-progress shadow load are untouched.
- Last vertex coincident with new_frame_in: the swap is not taken on that edge. The FSM enters PENDING and waits for the next new_frame_in.
- Persistence: the active buffer holds its contents indefinitely until the next swap. The same polygon is redrawn every frame.
- Storage: shadow writes never disturb xs_out/ys_out. Widths are stored unmodified; there is no arithmetic on coordinates.
- Reset (any state, including mid-LOAD or PENDING):
  - state=IDLE, count=0, overflow=0.
  - xs_out/ys_out all 0, num_points_out=0.
  - polygon_valid_out=0, swap_done_out=0, error_out=0.
  - The partially loaded shadow contents are discarded.
- Error and swap pulses are registered, one cycle wide, and never asserted simultaneously.

Test Plan:
- Reset, then stream 4 vertices (0,0),(100,0),(100,50),(0,50) with last on the 4th; pulse new_frame_in 10 cycles later -> ready low from cycle after 4th transfer; swap_done_out 1 cycle; num_points_out=4, xs_out[0..3]=0,100,100,0, xs_out[4..31]=0, polygon_valid_out=1; ready high again.
- Stream 2 vertices with last on 2nd -> error_out pulses once; state IDLE; active buffer and polygon_valid_out unchanged (0 after reset).
- MAX_NUM_VERTICES=32, stream 35 vertices, last on 35th -> all 35 accepted (ready stays high); error_out on 35th transfer; no swap on next new_frame_in.
- Load a 3-vertex polygon and swap; start a 5-vertex load and pulse new_frame_in after the 2nd vertex -> active still the 3-vertex polygon; finish the load and pulse new_frame_in -> num_points_out=5.
- Assert last vertex on the same edge as new_frame_in -> no swap_done_out; swap occurs on the next new_frame_in pulse.
- Assert rst_in while PENDING -> num_points_out=0, polygon_valid_out=0, ready high after rst_in deasserts; subsequent new_frame_in causes no swap.

Source files
------------

// File: rtl/polygon_vertex_loader.sv
`default_nettype none
// ============================================================================
// Module   : polygon_vertex_loader
// Purpose  : Double-buffered vertex store. Vertices stream into a shadow
//            buffer over valid/ready. A complete polygon is copied into the
//            active buffer that drives draw_polygon only at a frame boundary.
// Revision : 1.0  initial release
// ============================================================================
module polygon_vertex_loader #(
  parameter int MAX_NUM_VERTICES = 32,
  localparam int CNT_W = $clog2(MAX_NUM_VERTICES + 1)
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    new_frame_in,
  input  logic                    vertex_valid_in,
  output logic                    vertex_ready_out,
  input  logic signed [31:0]      vertex_x_in,
  input  logic signed [31:0]      vertex_y_in,
  input  logic                    vertex_last_in,
  output logic signed [31:0]      xs_out [MAX_NUM_VERTICES],
  output logic signed [31:0]      ys_out [MAX_NUM_VERTICES],
  output logic [CNT_W-1:0]        num_points_out,
  output logic                    polygon_valid_out,
  output logic                    swap_done_out,
  output logic                    error_out
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_NUM_VERTICES);
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(3);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_PENDING = 2'd2
  } state_t;

  state_t                 state_q;
  logic [CNT_W-1:0]       count_q;
  logic                   overflow_q;
  logic signed [31:0]     shadow_x_q [MAX_NUM_VERTICES];
  logic signed [31:0]     shadow_y_q [MAX_NUM_VERTICES];

  logic                   xfer;
  logic                   room;
  logic                   shadow_wr;
  logic [CNT_W-1:0]       wr_idx;
  logic [CNT_W-1:0]       final_cnt;
  logic                   load_bad;

  assign vertex_ready_out = (state_q != ST_PENDING) && !rst_in;
  assign xfer             = vertex_valid_in && vertex_ready_out;

  // A vertex is stored only while there is space; an IDLE transfer always
  // restarts the polygon at slot 0.
  assign room      = (count_q < MAX_CNT);
  assign wr_idx    = (state_q == ST_IDLE) ? '0 : count_q;
  assign shadow_wr = xfer && ((state_q == ST_IDLE) || room);

  // Vertex count once the current (last) vertex has been stored or dropped.
  assign final_cnt = room ? (count_q + 1'b1) : count_q;
  assign load_bad  = overflow_q || !room || (final_cnt < MIN_CNT);

  // Shadow buffer write port; contents are only meaningful below count_q.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
      if (shadow_wr && (wr_idx == CNT_W'(i))) begin
        shadow_x_q[i] <= vertex_x_in;
        shadow_y_q[i] <= vertex_y_in;
      end
    end
  end

  // Load/commit sequencer with registered active buffer and status pulses.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q           <= ST_IDLE;
      count_q           <= '0;
      overflow_q        <= 1'b0;
      num_points_out    <= '0;
      polygon_valid_out <= 1'b0;
      swap_done_out     <= 1'b0;
      error_out         <= 1'b0;
      for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
        xs_out[i] <= '0;
        ys_out[i] <= '0;
      end
    end else begin
      swap_done_out <= 1'b0;
      error_out     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (xfer) begin
            count_q    <= CNT_W'(1);
            overflow_q <= 1'b0;
            if (vertex_last_in) begin
              error_out <= 1'b1;
            end else begin
              state_q <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (xfer) begin
            if (room) begin
              count_q <= count_q + 1'b1;
            end else begin
              overflow_q <= 1'b1;
            end
            if (vertex_last_in) begin
              if (load_bad) begin
                error_out  <= 1'b1;
                overflow_q <= 1'b0;
                state_q    <= ST_IDLE;
              end else begin
                state_q <= ST_PENDING;
              end
            end
          end
        end
        ST_PENDING: begin
          // Frame boundary: publish the committed polygon, zero-filling
          // slots beyond its vertex count.
          if (new_frame_in) begin
            for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
              if (CNT_W'(i) < count_q) begin
                xs_out[i] <= shadow_x_q[i];
                ys_out[i] <= shadow_y_q[i];
              end else begin
                xs_out[i] <= '0;
                ys_out[i] <= '0;
              end
            end
            num_points_out    <= count_q;
            polygon_valid_out <= 1'b1;
            swap_done_out     <= 1'b1;
            state_q           <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_polygon_vertex_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_polygon_vertex_loader
// Purpose  : Self-checking bench: directed vector table, hand-written corner
//            sequences and random traffic against a queue-based model.
// Revision : 1.0  initial release
// ============================================================================
module tb_polygon_vertex_loader;

  localparam int MAXV = 32;
  localparam int NPW  = $clog2(MAXV + 1);

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               nf = 1'b0;
  logic               vld = 1'b0;
  logic               rdy;
  logic signed [31:0] vx = '0;
  logic signed [31:0] vy = '0;
  logic               vlast = 1'b0;
  logic signed [31:0] xs [MAXV];
  logic signed [31:0] ys [MAXV];
  logic [NPW-1:0]     np;
  logic               pv;
  logic               swp;
  logic               err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  polygon_vertex_loader #(.MAX_NUM_VERTICES(MAXV)) dut (
    .clk_in            (clk),
    .rst_in            (rst),
    .new_frame_in      (nf),
    .vertex_valid_in   (vld),
    .vertex_ready_out  (rdy),
    .vertex_x_in       (vx),
    .vertex_y_in       (vy),
    .vertex_last_in    (vlast),
    .xs_out            (xs),
    .ys_out            (ys),
    .num_points_out    (np),
    .polygon_valid_out (pv),
    .swap_done_out     (swp),
    .error_out         (err)
  );

  // ---------------- reference model (polygon-level view) -------------------
  logic signed [31:0] m_sx[$];
  logic signed [31:0] m_sy[$];
  bit                 m_busy, m_pend, m_ovf;
  logic signed [31:0] m_ax [MAXV];
  logic signed [31:0] m_ay [MAXV];
  int                 m_np;
  bit                 m_pv, m_swap, m_err;

  function automatic void model_step(input bit r, input bit f, input bit v,
                                     input logic signed [31:0] x,
                                     input logic signed [31:0] y,
                                     input bit l);
    if (r) begin
      m_sx.delete(); m_sy.delete();
      m_busy = 0; m_pend = 0; m_ovf = 0;
      for (int i = 0; i < MAXV; i++) begin m_ax[i] = 0; m_ay[i] = 0; end
      m_np = 0; m_pv = 0; m_swap = 0; m_err = 0;
      return;
    end
    m_swap = 0; m_err = 0;
    if (m_pend) begin
      if (f) begin
        for (int i = 0; i < MAXV; i++) begin
          m_ax[i] = (i < m_sx.size()) ? m_sx[i] : 0;
          m_ay[i] = (i < m_sy.size()) ? m_sy[i] : 0;
        end
        m_np = m_sx.size(); m_pv = 1; m_swap = 1; m_pend = 0;
      end
    end else if (v) begin
      if (!m_busy) begin
        m_sx.delete(); m_sy.delete();
        m_sx.push_back(x); m_sy.push_back(y);
        m_ovf = 0;
        if (l) m_err = 1;
        else   m_busy = 1;
      end else begin
        if (m_sx.size() < MAXV) begin m_sx.push_back(x); m_sy.push_back(y); end
        else m_ovf = 1;
        if (l) begin
          m_busy = 0;
          if (m_ovf || m_sx.size() < 3) begin m_err = 1; m_ovf = 0; end
          else m_pend = 1;
        end
      end
    end
  endfunction

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check ready before the edge, outputs after.
  task automatic step(input bit r, input bit f, input bit v,
                      input logic signed [31:0] x, input logic signed [31:0] y,
                      input bit l);
    int bad;
    @(negedge clk);
    rst = r; nf = f; vld = v; vx = x; vy = y; vlast = l;
    #1;
    chk("ready", rdy, (!m_pend && !r));
    model_step(r, f, v, x, y, l);
    @(posedge clk);
    #1;
    chk("swap_done", swp, m_swap);
    chk("error", err, m_err);
    chk("num_points", np, m_np);
    chk("poly_valid", pv, m_pv);
    bad = 0;
    for (int i = 0; i < MAXV; i++)
      if (xs[i] !== m_ax[i] || ys[i] !== m_ay[i]) bad++;
    chk("active_array_mismatches", bad, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- directed vector table ----------------------------------
  typedef struct {
    bit r, f, v;
    int x, y;
    bit l;
    bit e_rdy, e_swap, e_err;
    int e_np;
    bit e_pv;
  } vec_t;

  vec_t tab[$];

  function automatic void add(input bit r, input bit f, input bit v,
                              input int x, input int y, input bit l,
                              input bit e_rdy, input bit e_swap,
                              input bit e_err, input int e_np, input bit e_pv);
    vec_t t;
    t.r = r; t.f = f; t.v = v; t.x = x; t.y = y; t.l = l;
    t.e_rdy = e_rdy; t.e_swap = e_swap; t.e_err = e_err;
    t.e_np = e_np; t.e_pv = e_pv;
    tab.push_back(t);
  endfunction

  initial begin
    int bad;
    // Expected ready is the post-edge value with the row's inputs held.
    add(1,0,0,  0, 0,0, 0,0,0,0,0);
    add(0,0,0,  0, 0,0, 1,0,0,0,0);
    // two-vertex polygon is rejected
    add(0,0,1,  7, 7,0, 1,0,0,0,0);
    add(0,0,1,  8, 8,1, 1,0,1,0,0);
    add(0,0,0,  0, 0,0, 1,0,0,0,0);
    add(0,1,0,  0, 0,0, 1,0,0,0,0);
    // square, committed 10 cycles later
    add(0,0,1,  0, 0,0, 1,0,0,0,0);
    add(0,0,1,100, 0,0, 1,0,0,0,0);
    add(0,0,1,100,50,0, 1,0,0,0,0);
    add(0,0,1,  0,50,1, 0,0,0,0,0);
    for (int i = 0; i < 10; i++) add(0,0,1,999,999,0, 0,0,0,0,0);
    add(0,1,0,  0, 0,0, 1,1,0,4,1);
    add(0,0,0,  0, 0,0, 1,0,0,4,1);

    foreach (tab[k]) begin
      step(tab[k].r, tab[k].f, tab[k].v, tab[k].x, tab[k].y, tab[k].l);
      chk("tab_ready", rdy, tab[k].e_rdy);
      chk("tab_swap", swp, tab[k].e_swap);
      chk("tab_error", err, tab[k].e_err);
      chk("tab_np", np, tab[k].e_np);
      chk("tab_pv", pv, tab[k].e_pv);
    end
    chk("sq_x1", xs[1], 100);
    chk("sq_x2", xs[2], 100);
    chk("sq_y2", ys[2], 50);
    chk("sq_y3", ys[3], 50);
    bad = 0;
    for (int i = 4; i < MAXV; i++) if (xs[i] !== 0 || ys[i] !== 0) bad++;
    chk("sq_tail_zero", bad, 0);

    // 35-vertex overflow: all accepted, error on the last, no swap after.
    for (int i = 0; i < 35; i++) begin
      step(0, 0, 1, i * 3, -i, i == 34);
      if (i < 34) chk("ovf_ready_high", rdy, 1);
    end
    chk("ovf_error", err, 1);
    step(0, 1, 0, 0, 0, 0);
    chk("ovf_noswap", swp, 0);
    chk("ovf_np_kept", np, 4);

    // Frame pulse during a load leaves the active polygon alone.
    for (int i = 0; i < 3; i++) step(0, 0, 1, 10 + i, 20 + i, i == 2);
    step(0, 1, 0, 0, 0, 0);
    chk("tri_np", np, 3);
    step(0, 0, 1, -1, -2, 0);
    step(0, 0, 1, -3, -4, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("midload_noswap", swp, 0);
    chk("midload_np", np, 3);
    chk("midload_x0", xs[0], 10);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 40 + i, 50 + i, i == 2);
    idle(2);
    step(0, 1, 0, 0, 0, 0);
    chk("penta_np", np, 5);
    chk("penta_x4", xs[4], 42);

    // Last vertex coincident with a frame pulse: swap waits a frame.
    step(0, 0, 1, 1, 1, 0);
    step(0, 0, 1, 2, 2, 0);
    step(0, 1, 1, 3, 3, 1);
    chk("coinc_noswap", swp, 0);
    chk("coinc_pending", rdy, 0);
    idle(1);
    step(0, 1, 0, 0, 0, 0);
    chk("coinc_swap", swp, 1);
    chk("coinc_np", np, 3);

    // Reset while pending.
    for (int i = 0; i < 3; i++) step(0, 0, 1, 5, 6, i == 2);
    step(1, 0, 0, 0, 0, 0);
    idle(1);
    chk("rst_np", np, 0);
    chk("rst_pv", pv, 0);
    chk("rst_ready", rdy, 1);
    step(0, 1, 0, 0, 0, 0);
    chk("rst_noswap", swp, 0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(199) == 0,
           $urandom_range(9) == 0,
           $urandom_range(9) < 6,
           $urandom, $urandom,
           $urandom_range(99) < 12);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
